// File: rtl/lcd_pkg.sv
// Shared constants, FSM states and opcode decode for the HD44780-style bus receiver.
package lcd_pkg;

    localparam int         NCELLS     = 32;
    localparam logic [7:0] BLANK      = 8'h20;
    localparam logic [6:0] LINE1_BASE = 7'h40;

    // Instruction class is selected by the highest set bit of the opcode.
    localparam logic [7:0] OPM_CLEAR = 8'h01;
    localparam logic [7:0] OPM_HOME  = 8'h02;
    localparam logic [7:0] OPM_ENTRY = 8'h04;
    localparam logic [7:0] OPM_DISP  = 8'h08;
    localparam logic [7:0] OPM_SHIFT = 8'h10;
    localparam logic [7:0] OPM_FUNC  = 8'h20;
    localparam logic [7:0] OPM_CGRAM = 8'h40;
    localparam logic [7:0] OPM_DDRAM = 8'h80;

    localparam int ENTRY_ID_BIT = 1;
    localparam int DISP_D_BIT   = 2;
    localparam int SHIFT_SC_BIT = 3;
    localparam int SHIFT_RL_BIT = 2;

    typedef enum logic [1:0] {
        ST_RESET_CLR,
        ST_IDLE,
        ST_CLEAR,
        ST_BUSY
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP,
        OP_CLEAR,
        OP_HOME,
        OP_ENTRY,
        OP_DISP,
        OP_SHIFT,
        OP_FUNC,
        OP_CGRAM,
        OP_DDRAM
    } op_e;

    function automatic op_e decode_op(input logic [7:0] c);
        if      ((c & OPM_DDRAM) != 8'h00) return OP_DDRAM;
        else if ((c & OPM_CGRAM) != 8'h00) return OP_CGRAM;
        else if ((c & OPM_FUNC)  != 8'h00) return OP_FUNC;
        else if ((c & OPM_SHIFT) != 8'h00) return OP_SHIFT;
        else if ((c & OPM_DISP)  != 8'h00) return OP_DISP;
        else if ((c & OPM_ENTRY) != 8'h00) return OP_ENTRY;
        else if ((c & OPM_HOME)  != 8'h00) return OP_HOME;
        else if ((c & OPM_CLEAR) != 8'h00) return OP_CLEAR;
        return OP_NOP;
    endfunction

    // DDRAM address {line, col[3:0]} -> linear cell index line*16+col.
    function automatic logic [4:0] ddram_cell(input logic [6:0] a);
        return {|(a & LINE1_BASE), a[3:0]};
    endfunction

endpackage

// File: rtl/lcd_strobe_sync.sv
// Two-flop synchronizer for the LCD bus plus falling-edge detect of E with
// registered capture of RS/RW/DATA from the same synchronized stage.
module lcd_strobe_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data,
    output logic       stb,
    output logic       stb_rs,
    output logic       stb_rw,
    output logic [7:0] stb_data
);

    logic [10:0] s1_q, s2_q;
    logic        e_prev_q;
    logic        stb_q, rs_q, rw_q;
    logic [7:0]  data_q;
    logic        fall;

    // All bus lines share one synchronizer so a strobe sees a coherent bus word.
    assign fall = e_prev_q & ~s2_q[10];

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            e_prev_q <= 1'b0;
            stb_q    <= 1'b0;
            rs_q     <= 1'b0;
            rw_q     <= 1'b0;
            data_q   <= '0;
        end else begin
            s1_q     <= {lcd_e, lcd_rs, lcd_rw, lcd_data};
            s2_q     <= s1_q;
            e_prev_q <= s2_q[10];
            stb_q    <= fall;
            if (fall) begin
                rs_q   <= s2_q[9];
                rw_q   <= s2_q[8];
                data_q <= s2_q[7:0];
            end
        end
    end

    assign stb      = stb_q;
    assign stb_rs   = rs_q;
    assign stb_rw   = rw_q;
    assign stb_data = data_q;

endmodule

// File: rtl/lcd_bus_receiver.sv
// Display-side model of an HD44780-style 8-bit write bus: decodes strobes into
// instructions and character writes and keeps a readable 2x16 DDRAM image.
module lcd_bus_receiver
    import lcd_pkg::*;
#(
    parameter int CMD_BUSY  = 4,
    parameter int CLR_EXTRA = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic [4:0] cursor,
    output logic       busy,
    output logic       wr_pulse,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_char,
    output logic       cmd_pulse,
    output logic [7:0] cmd_code,
    output logic       display_on,
    output logic       err
);

    localparam int CNT_W = 8;

    logic       stb, stb_rs, stb_rw;
    logic [7:0] stb_data;

    lcd_strobe_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_data (lcd_data),
        .stb      (stb),
        .stb_rs   (stb_rs),
        .stb_rw   (stb_rw),
        .stb_data (stb_data)
    );

    state_e           state_q;
    logic [4:0]       fill_q;
    logic [CNT_W-1:0] cnt_q;
    logic [4:0]       cursor_q;
    logic             inc_q, tgt_dd_q;
    logic             busy_q, wr_pulse_q, cmd_pulse_q, disp_q, err_q;
    logic [4:0]       wr_addr_q;
    logic [7:0]       wr_char_q, cmd_code_q, rd_char_q;
    logic [7:0]       ddram_q [0:NCELLS-1];

    // The fill writes are internal and deliberately do not raise wr_pulse;
    // wr_pulse reports bus data writes only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_RESET_CLR;
            fill_q      <= '0;
            cnt_q       <= '0;
            cursor_q    <= '0;
            inc_q       <= 1'b1;
            tgt_dd_q    <= 1'b1;
            busy_q      <= 1'b1;
            wr_pulse_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_char_q   <= '0;
            cmd_pulse_q <= 1'b0;
            cmd_code_q  <= '0;
            disp_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_char_q   <= '0;
        end else begin
            wr_pulse_q  <= 1'b0;
            cmd_pulse_q <= 1'b0;
            rd_char_q   <= ddram_q[rd_addr];

            case (state_q)
                ST_RESET_CLR, ST_CLEAR: begin
                    ddram_q[fill_q] <= BLANK;
                    fill_q          <= fill_q + 5'd1;
                    if (fill_q == 5'(NCELLS - 1)) begin
                        if (state_q == ST_CLEAR) begin
                            state_q <= ST_BUSY;
                            cnt_q   <= CNT_W'(CLR_EXTRA - 1);
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase

            // Read strobes are ignored outright; anything else while busy is a violation.
            if (stb && !stb_rw) begin
                if (state_q != ST_IDLE) begin
                    err_q <= 1'b1;
                end else begin
                    state_q <= ST_BUSY;
                    busy_q  <= 1'b1;
                    cnt_q   <= CNT_W'(CMD_BUSY - 1);
                    if (stb_rs) begin
                        if (tgt_dd_q) begin
                            ddram_q[cursor_q] <= stb_data;
                            wr_pulse_q        <= 1'b1;
                            wr_addr_q         <= cursor_q;
                            wr_char_q         <= stb_data;
                            cursor_q          <= inc_q ? cursor_q + 5'd1 : cursor_q - 5'd1;
                        end
                    end else begin
                        cmd_pulse_q <= 1'b1;
                        cmd_code_q  <= stb_data;
                        case (decode_op(stb_data))
                            OP_CLEAR: begin
                                state_q  <= ST_CLEAR;
                                fill_q   <= '0;
                                cursor_q <= '0;
                                inc_q    <= 1'b1;
                            end
                            OP_HOME:  cursor_q <= '0;
                            OP_ENTRY: inc_q    <= stb_data[ENTRY_ID_BIT];
                            OP_DISP:  disp_q   <= stb_data[DISP_D_BIT];
                            OP_SHIFT: begin
                                if (!stb_data[SHIFT_SC_BIT])
                                    cursor_q <= stb_data[SHIFT_RL_BIT] ? cursor_q + 5'd1
                                                                       : cursor_q - 5'd1;
                            end
                            OP_CGRAM: tgt_dd_q <= 1'b0;
                            OP_DDRAM: begin
                                tgt_dd_q <= 1'b1;
                                cursor_q <= ddram_cell(stb_data[6:0]);
                                if (|stb_data[5:4]) err_q <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    assign rd_char    = rd_char_q;
    assign cursor     = cursor_q;
    assign busy       = busy_q;
    assign wr_pulse   = wr_pulse_q;
    assign wr_addr    = wr_addr_q;
    assign wr_char    = wr_char_q;
    assign cmd_pulse  = cmd_pulse_q;
    assign cmd_code   = cmd_code_q;
    assign display_on = disp_q;
    assign err        = err_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Scoreboard bench for lcd_bus_receiver: a cell-array model predicts pulses,
// cursor, flags and busy lengths; a monitor checks every pulse the DUT emits.
module tb_lcd_bus_receiver;

    localparam int CMD_BUSY  = 4;
    localparam int CLR_EXTRA = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
    logic [7:0] lcd_data = 8'h00;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] rd_char, wr_char, cmd_code;
    logic [4:0] cursor, wr_addr;
    logic       busy, wr_pulse, cmd_pulse, display_on, err;

    lcd_bus_receiver #(.CMD_BUSY(CMD_BUSY), .CLR_EXTRA(CLR_EXTRA)) dut (
        .clk(clk), .rst(rst), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_data(lcd_data), .rd_addr(rd_addr), .rd_char(rd_char), .cursor(cursor),
        .busy(busy), .wr_pulse(wr_pulse), .wr_addr(wr_addr), .wr_char(wr_char),
        .cmd_pulse(cmd_pulse), .cmd_code(cmd_code), .display_on(display_on), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_cmd;
        logic [7:0] code;
        logic [4:0] addr;
        logic [7:0] ch;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    logic [7:0] m_mem [32];
    int         m_cur;
    bit         m_inc, m_dd, m_err, m_disp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (wr_pulse || cmd_pulse) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, wr_pulse, cmd_pulse}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_kind", {30'd0, wr_pulse, cmd_pulse}, e.is_cmd ? 32'd1 : 32'd2);
                if (e.is_cmd) begin
                    chk("cmd_code", cmd_code, e.code);
                end else begin
                    chk("wr_addr", wr_addr, e.addr);
                    chk("wr_char", wr_char, e.ch);
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
        m_cur = 0; m_inc = 1; m_dd = 1; m_err = 0; m_disp = 0;
    endtask

    // Reference behaviour of one accepted write; len is the expected busy length.
    task automatic model_apply(input bit rs, input logic [7:0] d, output int len);
        ev_t e;
        int  top;
        len = CMD_BUSY;
        if (rs) begin
            if (m_dd) begin
                m_mem[m_cur] = d;
                e.is_cmd = 0; e.code = 8'h00; e.addr = m_cur[4:0]; e.ch = d;
                exp_q.push_back(e);
                m_cur = m_inc ? (m_cur + 1) % 32 : (m_cur + 31) % 32;
            end
            return;
        end
        e.is_cmd = 1; e.code = d; e.addr = 5'd0; e.ch = 8'h00;
        exp_q.push_back(e);
        top = -1;
        for (int i = 7; i >= 0; i--) if (d[i] && top < 0) top = i;
        case (top)
            0: begin
                for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
                m_cur = 0; m_inc = 1;
                len = 32 + CLR_EXTRA;
            end
            1: m_cur = 0;
            2: m_inc = d[1];
            3: m_disp = d[2];
            4: if (!d[3]) m_cur = d[2] ? (m_cur + 1) % 32 : (m_cur + 31) % 32;
            6: m_dd = 0;
            7: begin
                m_dd = 1;
                m_cur = (d[6] ? 16 : 0) + int'(d[3:0]);
                if (d[5:4] != 2'b00) m_err = 1;
            end
            default: ;
        endcase
    endtask

    task automatic wait_busy_fall(output int n);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (!busy) break;
        end
    endtask

    task automatic do_reset(input bit mid);
        int n;
        @(negedge clk);
        rst = 0; lcd_e = 0; lcd_rw = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1);
        chk("rst_cursor", cursor, 0);
        chk("rst_wr_pulse", wr_pulse, 0);
        chk("rst_cmd_pulse", cmd_pulse, 0);
        chk("rst_err", err, 0);
        chk("rst_display_on", display_on, 0);
        chk("rst_rd_char", rd_char, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_char", wr_char, 0);
        chk("rst_cmd_code", cmd_code, 0);
        model_reset();
        rst = 1;
        if (mid) begin
            repeat (12) @(negedge clk);
            chk("busy_midfill", busy, 1);
            rst = 0;
            @(negedge clk);
            rst = 1;
        end
        wait_busy_fall(n);
        chk("reset_busy_fall_cycle", n, 32);
    endtask

    task automatic send(input bit rs, input logic [7:0] d);
        int len, lat, n;
        bit seen;
        model_apply(rs, d, len);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = 0; lcd_data = d; lcd_e = 1;
        repeat (2) @(negedge clk);
        lcd_e = 0;
        lat = 0; seen = 0;
        while (!seen && lat < 10) begin
            @(negedge clk);
            lat++;
            if (busy) seen = 1;
        end
        chk("strobe_latency", lat, 4);
        if (seen) begin
            n = 1;
            while (n < 200) begin
                @(negedge clk);
                if (!busy) break;
                n++;
            end
            chk("busy_len", n, len);
        end
        chk("cursor", cursor, m_cur[4:0]);
        chk("err", err, m_err);
        chk("display_on", display_on, m_disp);
    endtask

    task automatic send_rw1(input logic [7:0] d);
        bit any;
        @(negedge clk);
        lcd_rs = 1; lcd_rw = 1; lcd_data = d; lcd_e = 1;
        repeat (2) @(negedge clk);
        lcd_e = 0;
        any = 0;
        repeat (10) begin
            @(negedge clk);
            any |= busy;
        end
        lcd_rw = 0;
        chk("rw1_busy", any, 0);
        chk("rw1_cursor", cursor, m_cur[4:0]);
        chk("rw1_err", err, m_err);
    endtask

    // Second strobe lands while the first write still holds busy.
    task automatic busy_violation();
        int len;
        model_apply(1, 8'h55, len);
        @(negedge clk);
        lcd_rs = 1; lcd_rw = 0; lcd_data = 8'h55; lcd_e = 1;
        repeat (2) @(negedge clk);
        lcd_e = 0;
        @(negedge clk);
        lcd_data = 8'h66; lcd_e = 1;
        @(negedge clk);
        lcd_e = 0;
        m_err = 1;
        repeat (20) @(negedge clk);
        chk("viol_err", err, 1);
        chk("viol_cursor", cursor, m_cur[4:0]);
        chk("viol_busy", busy, 0);
    endtask

    task automatic clear_with_reset();
        int len, lat, n;
        model_apply(0, 8'h01, len);
        @(negedge clk);
        lcd_rs = 0; lcd_rw = 0; lcd_data = 8'h01; lcd_e = 1;
        repeat (2) @(negedge clk);
        lcd_e = 0;
        lat = 0;
        while (!busy && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("clr_latency", lat, 4);
        repeat (10) @(negedge clk);
        chk("clr_busy_midfill", busy, 1);
        rst = 0;
        @(negedge clk);
        chk("clr_rst_busy", busy, 1);
        chk("clr_rst_cursor", cursor, 0);
        model_reset();
        rst = 1;
        wait_busy_fall(n);
        chk("clr_reset_busy_fall_cycle", n, 32);
    endtask

    task automatic check_cells(input string tag);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            rd_addr = 5'(i);
            @(negedge clk);
            chk(tag, rd_char, m_mem[i]);
        end
    endtask

    initial begin
        int r;
        model_reset();
        do_reset(0);
        check_cells("rd_reset_fill");
        chk("cursor_after_reset", cursor, 0);
        do_reset(1);
        check_cells("rd_reset_restart");

        send(1, 8'h32);
        send(1, 8'h33);
        send(0, 8'hC0);
        send(1, 8'h34);
        send(0, 8'h90);
        send(0, 8'h8F);
        send(1, 8'h41);
        send(0, 8'hCF);
        send(1, 8'h42);
        send(0, 8'h04);
        send(1, 8'h43);
        send(0, 8'h0C);
        send(0, 8'h14);
        send(0, 8'h10);
        send(0, 8'h1C);
        send(0, 8'h08);
        send(0, 8'h38);
        check_cells("rd_directed");

        do_reset(0);
        send_rw1(8'h77);
        busy_violation();
        send_rw1(8'h78);
        send(1, 8'h58);
        send(0, 8'h40);
        send(1, 8'h59);
        send(0, 8'h86);
        send(1, 8'h5A);
        check_cells("rd_violation");
        send(0, 8'h01);
        check_cells("rd_clear");
        send(1, 8'h61);
        send(1, 8'h62);
        clear_with_reset();
        check_cells("rd_clear_reset");

        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 15);
            if (r < 8)       send(1, 8'($urandom_range(0, 255)));
            else if (r == 8) send(0, 8'h01);
            else if (r < 11) send(0, 8'h80 | 8'($urandom_range(0, 127)));
            else             send(0, 8'($urandom_range(0, 127)));
        end
        check_cells("rd_random");
        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_bus_receiver.md
# lcd_bus_receiver

Display-side receiver for the calculator's HD44780-style 8-bit LCD write bus (`lcd_e`, `lcd_rs`, `lcd_rw`, `lcd_data`). It sits at the far end of the bus, where the physical LCD would be, and decodes every write strobe into commands or character writes. It maintains a 2×16 DDRAM character image that can be read back. It is a synthesizable on-chip display model and also serves as the bus checker in calculator simulations.

## Interface
- `CMD_BUSY`, default 4: busy cycles after each accepted command or data write.
- `CLR_EXTRA`, default 8: busy cycles added after the 32-cell clear fill.
- `clk  in  1`: system clock.
- `rst  in  1`: synchronous, active-low reset. One clock; reset is synchronous and active-low.
- `lcd_e  in  1`: bus enable; a write is taken on its falling edge.
- `lcd_rs  in  1`: 0 = instruction, 1 = data.
- `lcd_rw  in  1`: 0 = write; 1 = read, which is ignored.
- `lcd_data  in  8`: bus data.
- `rd_addr  in  5`: read-back cell index, computed as line×16+col.
- `rd_char  out  8`: DDRAM[rd_addr], registered.
- `cursor  out  5`: current address counter.
- `busy  out  1`: high while the receiver is not accepting strobes.
- `wr_pulse  out  1`: one-cycle pulse on each DDRAM write.
- `wr_addr  out  5` / `wr_char  out  8`: cell index and character of the write; valid with `wr_pulse`.
- `cmd_pulse  out  1` / `cmd_code  out  8`: one-cycle pulse and opcode of each accepted instruction.
- `display_on  out  1`: D bit from the last display-control instruction.
- `err  out  1`: sticky protocol error, cleared only by reset.

## Operation
- `lcd_e`, `lcd_rs`, `lcd_rw` and `lcd_data` pass through the same 2-flop synchronizer.
- A strobe is a 1→0 transition of synchronized `lcd_e`. `rs`, `rw` and `data` are captured from the same pipeline stage.
- Strobes with `rw`=1 are ignored: no state change and no error.
- A strobe while `busy`=1 is dropped and sets `err`.
- Instructions (`rs`=0) are decoded by the highest set bit:
  - 0x01, clear: enter the CLEAR state, write 0x20 to cells 0..31 at one per cycle, set cursor=0 and increment mode.
  - 0x02/0x03, home: cursor=0.
  - 0b000001 I S, entry mode: inc = bit1. S is ignored.
  - 0b00001DCB, display control: `display_on`=D.
  - 0b0001 S R xx, shift: if S=0, move cursor +1 when R=1, else −1. Wraps as for data writes. S=1 is ignored.
  - 0b001xxxxx, function set: accepted, no effect.
  - 0b01xxxxxx, CGRAM address: target=CGRAM. Later data writes are accepted but discarded, with no `wr_pulse`.
  - 0b1aaaaaaa, DDRAM address: target=DDRAM, cursor = {a[6], a[3:0]}. If a[5:4]≠0, also set `err`.
- Data (`rs`=1) with target=DDRAM: DDRAM[cursor]=data, pulse `wr_pulse`, then step the cursor.
  - Increment: 15→16, 31→0.
  - Decrement: 16→15, 0→31.
- State machine states:
  - RESET_CLR goes to IDLE after 32 fill cycles.
  - IDLE goes to BUSY on an accepted strobe, or to CLEAR on 0x01.
  - CLEAR goes to BUSY after 32 fill cycles, with the busy count set to CLR_EXTRA.
  - BUSY goes to IDLE when the counter reaches 0.

## Timing
- Reset values while `rst`=0:
  - `busy`=1 (held by RESET_CLR).
  - `cursor`=0, `wr_pulse`=0, `cmd_pulse`=0, `err`=0, `display_on`=0, `rd_char`=0x00, `wr_addr`=0, `wr_char`=0, `cmd_code`=0.
  - Target=DDRAM, increment mode.
- After release, RESET_CLR fills all cells with 0x20. `busy` falls in cycle 32 after release.
- A reset asserted during any fill restarts the fill from cell 0.
- Strobe latency: `lcd_e` is first sampled low at edge n. The strobe is detected at edge n+2. `wr_pulse` or `cmd_pulse`, the DDRAM write, the cursor update and `busy`=1 all appear after edge n+3.
- `busy` stays high for CMD_BUSY cycles. For clear, it stays high for 32+CLR_EXTRA cycles.
- `rd_char` has a 1-cycle latency from `rd_addr`.
- Read/write collision on the same cell: `rd_char` returns the new value one cycle after the write.
- A strobe whose detection coincides with the cycle `busy` falls is accepted.

## Structure
- Package `lcd_pkg` holds:
  - opcode masks and constants;
  - BLANK=8'h20, NCELLS=32, LINE1_BASE=7'h40;
  - the state enum.
- Sub-module `lcd_strobe_sync`: 2-flop synchronizer, falling-edge detect, and registered capture of rs/rw/data. It outputs `stb`, `stb_rs`, `stb_rw` and `stb_data`.
- DDRAM is a 32×8 register array inside `lcd_bus_receiver`.

## Test plan
- Reset: release `rst` and wait for `busy`=0. Then `busy` falls at cycle 32, all 32 `rd_char` reads return 0x20, and `cursor`=0.
- Data writes: write 0x32, then 0x33. Cells 0 and 1 hold 0x32 and 0x33, there are two `wr_pulse`s, and `cursor`=2.
- Line 2: send 0xC0, then data 0x34. Cell 16 holds 0x34 and `cursor`=17. Sending 0x90 sets `err`=1 and `cursor`=0.
- Wrap and decrement:
  - With cursor=15, writing 0x41 puts it in cell 15 and cursor becomes 16.
  - With cursor=31, a write wraps the cursor to 0.
  - After 0x04 (decrement), a write at cell 0 leaves cursor=31.
- Busy violation: a strobe 1 cycle after an accepted write is dropped. There is no `wr_pulse`, `err`=1 stays set until reset, and a strobe with `rw`=1 changes nothing.
- Clear: over written content, send 0x01. `busy` stays high for 40 cycles and all cells return 0x20. Asserting `rst` mid-fill restarts the fill from cell 0.
